des_decrypt_core: RTL and testbench

DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

---
 rtl/des_decrypt_core.sv | 232 +++++++++++++++++++++++
 tb/tb_des_decrypt_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_core.sv
// Iterative DES block core: one Feistel round per clock, 16 rounds per block.
// Decrypt-only by default; defining DES_ENCRYPT_MODE_EN adds the mode_enc port for encryption.
module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dat_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] dat_out
`ifdef DES_ENCRYPT_MODE_EN
    ,
    input  logic        mode_enc
`endif
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // ROUND | one Feistel round per cycle, counter 0..15
    // DONE  | dat_out valid, held until out_ready
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    // Tables hold DES bit numbers (1 = MSB), hence the width-minus-entry indexing.
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  ch;
        for (int j = 0; j < 48; j++) x[6'(47 - j)] = r[5'(32 - E_T[j])];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            ch = x[6'(42 - 6 * b) +: 6];
            s[5'(28 - 4 * b) +: 4] = 4'(SBOX[3'(b)][{ch[5], ch[0], ch[4:1]}]);
        end
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = s[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic two);
        case ({left, two})
            2'b00:   rot = {x[0], x[27:1]};
            2'b01:   rot = {x[1:0], x[27:2]};
            2'b10:   rot = {x[26:0], x[27]};
            default: rot = {x[25:0], x[27:26]};
        endcase
    endfunction

    // Rounds 1, 2, 9 and 16 of the key schedule shift by one, all others by two.
    function automatic logic two_shift(input logic [4:0] i);
        return !(i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [63:0] out_q, out_d;
    logic        enc, enc_in;
    logic [4:0]  next_round;
    logic [47:0] subkey;
    logic [31:0] f_out;
    logic [63:0] dat_ip;
    logic [55:0] key_pc1;

`ifdef DES_ENCRYPT_MODE_EN
    logic enc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               enc_q <= 1'b0;
        else if (state_q == IDLE && in_valid)     enc_q <= mode_enc;
    end
    assign enc    = enc_q;
    assign enc_in = mode_enc;
`else
    assign enc    = 1'b0;
    assign enc_in = 1'b0;
`endif

    assign dat_ip  = perm_ip(dat_in);
    assign key_pc1 = perm_pc1(key_in);
    assign subkey  = perm_pc2({c_q, d_q});
    assign f_out   = feistel(r_q, subkey);
    // Each round cycle prepares C/D for the following round.
    assign next_round = enc ? ({1'b0, cnt_q} + 5'd2) : (5'd16 - {1'b0, cnt_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = dat_ip[63:32];
                    r_d     = dat_ip[31:0];
                    c_d     = enc_in ? rot(key_pc1[55:28], 1'b1, 1'b0) : key_pc1[55:28];
                    d_d     = enc_in ? rot(key_pc1[27:0], 1'b1, 1'b0) : key_pc1[27:0];
                    cnt_d   = 4'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                c_d   = rot(c_q, enc, two_shift(next_round));
                d_d   = rot(d_q, enc, two_shift(next_round));
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    out_d   = perm_fp({l_q ^ f_out, r_q});
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            l_q     <= 32'd0;
            r_q     <= 32'd0;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            out_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dat_out   = out_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: known-answer vectors, DES complement
// property, parity-bit insensitivity, back-pressure hold and mid-block reset.
module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dat_in;
    logic [63:0] key_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dat_out;
`ifdef DES_ENCRYPT_MODE_EN
    logic        mode_enc;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    always #5 clk = ~clk;

    des_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dat_in    (dat_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dat_out   (dat_out)
`ifdef DES_ENCRYPT_MODE_EN
        ,
        .mode_enc  (mode_enc)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic drive(input logic [63:0] key, input logic [63:0] dat,
                         input logic [63:0] exp, input logic enc);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        key_in   = key;
        dat_in   = dat;
        in_valid = 1'b1;
`ifdef DES_ENCRYPT_MODE_EN
        mode_enc = enc;
`else
        if (enc) $display("note: encrypt request ignored in decrypt-only build");
`endif
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
        key_in   = {$urandom, $urandom};
        dat_in   = {$urandom, $urandom};
    endtask

    // Waits for the result, checks latency and data, optionally holds back-pressure.
    task automatic collect(input string tag, input int hold, input logic ready_early,
                           input logic scramble);
        int          n = 0;
        logic [63:0] exp = 64'd0;
        out_ready = ready_early;
        while (n < 40) begin
            if (scramble) begin
                in_valid = 1'b1;
                key_in   = {$urandom, $urandom};
                dat_in   = {$urandom, $urandom};
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n, 16);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, "_data"}, dat_out, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dat_in   = {$urandom, $urandom};
            key_in   = {$urandom, $urandom};
            @(negedge clk);
            check({tag, "_hold_data"}, dat_out, exp);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_valid_after"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        key_in    = K1;
        dat_in    = C1;
        out_ready = 1'b0;
`ifdef DES_ENCRYPT_MODE_EN
        mode_enc  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_dat_out", dat_out, 64'd0);

        // Block presented while reset releases is taken on the very first edge.
        rst_n = 1'b1;
        @(posedge clk);
        exp_q.push_back(P1);
        #1;
        in_valid = 1'b0;
        collect("kat1_first", 0, 1'b0, 1'b0);

        drive(K2, C2, P2, 1'b0);
        collect("kat2_hold", 10, 1'b0, 1'b0);

        drive(~K1, ~C1, ~P1, 1'b0);
        collect("compl1_rdy", 0, 1'b1, 1'b0);

        drive(~K2, ~C2, ~P2, 1'b0);
        collect("compl2", 2, 1'b0, 1'b0);

        drive(K1 ^ PARITY, C1, P1, 1'b0);
        collect("parity", 0, 1'b0, 1'b0);

        drive(K1, C1, P1, 1'b0);
        collect("scramble", 0, 1'b0, 1'b1);

        // Abort in the middle of the rounds.
        drive(K2, C2, P2, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_dat_out", dat_out, 64'd0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        check("abort_dat_idle", dat_out, 64'd0);

        drive(K1, C1, P1, 1'b0);
        collect("after_abort", 0, 1'b0, 1'b0);

`ifdef DES_ENCRYPT_MODE_EN
        drive(K1, P1, C1, 1'b1);
        collect("encrypt_kat1", 0, 1'b0, 1'b0);
        drive(K2, P2, C2, 1'b1);
        collect("encrypt_kat2", 0, 1'b0, 1'b0);
        drive(K1, C1, P1, 1'b0);
        collect("decrypt_again", 0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
